// File: rtl/pipelined_mult_unit.sv
// Pipelined RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU) with ROB tags,
// speculative kill/resolve tracking and an elastic, bubble-collapsing pipeline.
module pipelined_mult_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_func,
    input  logic [XLEN-1:0]  in_opa,
    input  logic [XLEN-1:0]  in_opb,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_spec,
    input  logic             kill,
    input  logic             resolve,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_value,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_spec,
    output logic             busy
);

    localparam int LAST = STAGES - 1;
    localparam int PW   = 2 * XLEN;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and a stalled producer holds its payload.

    // Sign/zero-extend each operand to 2*XLEN so one unsigned multiply gives the
    // correct low 2*XLEN bits for every signedness combination.
    function automatic logic [PW-1:0] full_product(input logic [1:0] func,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = {{XLEN{a[XLEN-1] & (func != 2'b11)}}, a};
        eb = {{XLEN{b[XLEN-1] & (func[1] == 1'b0)}}, b};
        return ea * eb;
    endfunction

    function automatic logic [XLEN-1:0] select_result(input logic [1:0] func,
                                                      input logic [PW-1:0] prod);
        return (func == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    endfunction

    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_spec;
    logic [STAGES-1:0] can_take;
    logic [1:0]        st_func [STAGES];
    logic [TAG_W-1:0]  st_tag  [STAGES];
    logic [PW-1:0]     st_data [STAGES];   // stage 0: {opa, opb}; later stages: product
    logic [PW-1:0]     stage0_product;
    logic              accept;

    // can_take[k]: stage k is empty or will hand its entry downstream this edge.
    always_comb begin
        logic ok;
        can_take = '0;
        ok = !st_valid[LAST] || out_ready;
        can_take[LAST] = ok;
        for (int k = LAST - 1; k >= 0; k--) begin
            ok = !st_valid[k] || ok;
            can_take[k] = ok;
        end
    end

    assign stage0_product = full_product(st_func[0], st_data[0][PW-1:XLEN], st_data[0][XLEN-1:0]);
    assign in_ready       = !reset && can_take[0];
    assign accept         = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_valid <= '0;
            st_spec  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_func[k] <= '0;
                st_tag[k]  <= '0;
                st_data[k] <= '0;
            end
        end else begin
            if (can_take[0]) begin
                st_valid[0] <= accept && !(kill && in_spec);
                st_spec[0]  <= in_spec && !resolve;
                if (accept) begin
                    st_func[0] <= in_func;
                    st_tag[0]  <= in_tag;
                    st_data[0] <= {in_opa, in_opb};
                end
            end else begin
                st_valid[0] <= st_valid[0] && !(kill && st_spec[0]);
                st_spec[0]  <= st_spec[0] && !resolve;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (can_take[k]) begin
                    st_valid[k] <= st_valid[k-1] && !(kill && st_spec[k-1]);
                    st_spec[k]  <= st_spec[k-1] && !resolve;
                    if (st_valid[k-1]) begin
                        st_func[k] <= st_func[k-1];
                        st_tag[k]  <= st_tag[k-1];
                        st_data[k] <= (k == 1) ? stage0_product : st_data[k-1];
                    end
                end else begin
                    st_valid[k] <= st_valid[k] && !(kill && st_spec[k]);
                    st_spec[k]  <= st_spec[k] && !resolve;
                end
            end
        end
    end

    // A single-stage unit still holds raw operands in its only register.
    assign out_value = (STAGES == 1) ? select_result(st_func[0], stage0_product)
                                     : select_result(st_func[LAST], st_data[LAST]);
    assign out_tag   = st_tag[LAST];
    assign out_valid = st_valid[LAST] && !(kill && st_spec[LAST]);
    assign out_spec  = st_spec[LAST] && !resolve;
    assign busy      = |st_valid;

endmodule
